// File: rtl/ber_sync_ctrl.sv
// Candidate-latency sweep sequencer for the BER counter: registered outputs, one-clk update latency, advances only on i_ctrl.
// Optional LOS-driven resync from COUNT back to SYNC is compiled in with `BER_AUTO_RESYNC_EN.
module ber_sync_ctrl #(
   parameter int PRBS_MAX_CYCLES = 511,
   parameter int WINDOW_LEN      = 1023,
   parameter int LOS_LIMIT       = 4096
) (
   input  logic                               clk,
   input  logic                               i_reset,
   input  logic                               i_ctrl,
   input  logic                               i_start,
   input  logic                               i_ber_ok,
   output logic                               o_synchro_en,
   output logic                               o_prbs_cmp_curr_addr_done,
   output logic                               o_ber_counter_en,
   output logic                               o_ber_clear,
   output logic [$clog2(PRBS_MAX_CYCLES)-1:0] o_cand_idx,
   output logic [1:0]                         o_state
);

   localparam int CW = $clog2(PRBS_MAX_CYCLES);
   localparam int WW = $clog2(WINDOW_LEN + 1);
   localparam logic [CW-1:0] C_LAST = CW'(PRBS_MAX_CYCLES - 1);
   localparam logic [WW-1:0] W_MAX  = WW'(WINDOW_LEN);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SYNC  = 2'b01,
      COUNT = 2'b10
   } state_t;

   state_t          state_q;
   logic [WW-1:0]   w_q;
   logic [CW-1:0]   cand_q;
   logic            done_q;
   logic            clr_q;
   logic            sync_q;
   logic            cnt_q;

`ifdef BER_AUTO_RESYNC_EN
   localparam int LW = $clog2(LOS_LIMIT + 1);
   localparam logic [LW-1:0] L_MAX = LW'(LOS_LIMIT);
   logic [LW-1:0]   los_q;
`else
   logic unused_cfg;
   assign unused_cfg = i_ber_ok ^ (LOS_LIMIT == 0);
`endif

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         w_q     <= '0;
         cand_q  <= '0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
         sync_q  <= 1'b0;
         cnt_q   <= 1'b0;
`ifdef BER_AUTO_RESYNC_EN
         los_q   <= '0;
`endif
      end else begin
         clr_q <= 1'b0;
         if (!i_start) begin
            // Dropping i_start abandons the sweep; it always restarts from candidate 0.
            state_q <= IDLE;
            w_q     <= '0;
            cand_q  <= '0;
            done_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= 1'b0;
`ifdef BER_AUTO_RESYNC_EN
            los_q   <= '0;
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= SYNC;
                  sync_q  <= 1'b1;
                  clr_q   <= 1'b1;
                  w_q     <= '0;
                  cand_q  <= '0;
                  done_q  <= 1'b0;
               end
               SYNC: begin
                  if (i_ctrl) begin
                     if (w_q != W_MAX) begin
                        w_q    <= w_q + WW'(1);
                        done_q <= ((w_q + WW'(1)) == W_MAX);
                     end else begin
                        // The strobe after the done phase closes this candidate's window.
                        w_q    <= '0;
                        done_q <= 1'b0;
                        if (cand_q != C_LAST) begin
                           cand_q <= cand_q + CW'(1);
                        end else begin
                           cand_q  <= '0;
                           state_q <= COUNT;
                           sync_q  <= 1'b0;
                           cnt_q   <= 1'b1;
`ifdef BER_AUTO_RESYNC_EN
                           los_q   <= '0;
`endif
                        end
                     end
                  end
               end
               COUNT: begin
`ifdef BER_AUTO_RESYNC_EN
                  if (i_ctrl) begin
                     if (i_ber_ok) begin
                        los_q <= '0;
                     end else if ((los_q + LW'(1)) == L_MAX) begin
                        state_q <= SYNC;
                        sync_q  <= 1'b1;
                        cnt_q   <= 1'b0;
                        clr_q   <= 1'b1;
                        cand_q  <= '0;
                        w_q     <= '0;
                        done_q  <= 1'b0;
                        los_q   <= '0;
                     end else begin
                        los_q <= los_q + LW'(1);
                     end
                  end
`endif
               end
               default: begin
                  state_q <= IDLE;
                  sync_q  <= 1'b0;
                  cnt_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_synchro_en              = sync_q;
   assign o_prbs_cmp_curr_addr_done = done_q;
   assign o_ber_counter_en          = cnt_q;
   assign o_ber_clear               = clr_q;
   assign o_cand_idx                = cand_q;
   assign o_state                   = state_q;

endmodule

// File: tb/tb_ber_sync_ctrl.sv
// Scoreboard bench for ber_sync_ctrl: a strobe-count reference model predicts every registered output.
module tb_ber_sync_ctrl;
   localparam int P   = 4;
   localparam int WL  = 3;
   localparam int LIM = 8;
   localparam int CW  = $clog2(P);

   logic          clk;
   logic          i_reset, i_ctrl, i_start, i_ber_ok;
   logic          o_synchro_en, o_prbs_cmp_curr_addr_done, o_ber_counter_en, o_ber_clear;
   logic [CW-1:0] o_cand_idx;
   logic [1:0]    o_state;

   ber_sync_ctrl #(.PRBS_MAX_CYCLES(P), .WINDOW_LEN(WL), .LOS_LIMIT(LIM)) dut (
      .clk                       (clk),
      .i_reset                   (i_reset),
      .i_ctrl                    (i_ctrl),
      .i_start                   (i_start),
      .i_ber_ok                  (i_ber_ok),
      .o_synchro_en              (o_synchro_en),
      .o_prbs_cmp_curr_addr_done (o_prbs_cmp_curr_addr_done),
      .o_ber_counter_en          (o_ber_counter_en),
      .o_ber_clear               (o_ber_clear),
      .o_cand_idx                (o_cand_idx),
      .o_state                   (o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   // Model: mode 0 idle, 1 sync, 2 count; s = strobes since entering SYNC.
   int md  = 0;
   int s   = 0;
   int los = 0;
   bit clr = 0;
   bit prev_rst = 0;

   function automatic logic [7:0] dut_vec();
      return {o_state, o_synchro_en, o_prbs_cmp_curr_addr_done, o_ber_counter_en, o_ber_clear, o_cand_idx};
   endfunction

   function automatic logic [7:0] model_vec();
      logic [1:0]    st;
      logic [CW-1:0] cand;
      bit            done;
      st   = 2'(md);
      cand = (md == 1) ? CW'(s / (WL + 1)) : '0;
      done = (md == 1) && ((s % (WL + 1)) == WL);
      return {st, md == 1, done, md == 2, clr, cand};
   endfunction

   task automatic model_step(input bit rst, input bit start, input bit ctrl, input bit ok);
      clr = 0;
      if (!rst || !start) begin
         md = 0; s = 0; los = 0;
      end else if (md == 0) begin
         md = 1; s = 0; clr = 1;
      end else if (md == 1) begin
         if (ctrl) begin
            s++;
            if (s == P * (WL + 1)) begin md = 2; s = 0; los = 0; end
         end
      end else begin
`ifdef BER_AUTO_RESYNC_EN
         if (ctrl) begin
            if (ok) los = 0;
            else begin
               los++;
               if (los == LIM) begin md = 1; s = 0; los = 0; clr = 1; end
            end
         end
`else
         if (ok && ctrl) md = 2;
`endif
      end
   endtask

   task automatic drive(input bit rst, input bit start, input bit ctrl, input bit ok);
      @(negedge clk);
      i_reset = rst; i_start = start; i_ctrl = ctrl; i_ber_ok = ok;
      if (!rst && prev_rst) begin
         #1;
         checks++;
         if (dut_vec() != 8'h00) begin
            failures++;
            $display("FAIL async_reset got=%h want=00", dut_vec());
         end
      end
      prev_rst = rst;
      model_step(rst, start, ctrl, ok);
      exp_q.push_back(model_vec());
   endtask

   task automatic run_until(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (md != target && k < budget) begin
         drive(1, 1, (k % 2) == 0, 1);
         k++;
      end
      checks++;
      if (md != target) begin
         failures++;
         $display("FAIL %s reached_mode=%0d want=%0d", name, md, target);
      end
   endtask

   // Monitor: every clock the DUT presents a registered output word.
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_vec() != e) begin
               failures++;
               $display("FAIL scoreboard t=%0t got st=%b sy=%b dn=%b ce=%b cl=%b ci=%0d want st=%b sy=%b dn=%b ce=%b cl=%b ci=%0d",
                        $time, dut_vec()[7:6], dut_vec()[5], dut_vec()[4], dut_vec()[3], dut_vec()[2], dut_vec()[CW-1:0],
                        e[7:6], e[5], e[4], e[3], e[2], e[CW-1:0]);
            end
         end
      end
   end

   initial begin
      int k;
      i_reset = 1'b0; i_start = 1'b0; i_ctrl = 1'b0; i_ber_ok = 1'b0;
      // T1: reset, then idle with strobes toggling.
      for (int i = 0; i < 3; i++) drive(0, 0, i[0], 0);
      for (int i = 0; i < 100; i++) drive(1, 0, i[0], $urandom_range(0, 1) == 1);
      // T2: full sweep with a strobe every 4th clock, then settle in COUNT.
      for (int i = 0; i < 80; i++) drive(1, 1, (i % 4) == 3, 1);
      // T3: abort at cand 2, w 1, then restart.
      drive(1, 0, 0, 1);
      drive(1, 1, 0, 1);
      k = 0;
      while (!(md == 1 && s == 9) && k < 100) begin drive(1, 1, 1, 1); k++; end
      checks++;
      if (!(md == 1 && s == 9)) begin failures++; $display("FAIL abort_setup got_s=%0d want=9", s); end
      drive(1, 0, 1, 1);
      drive(1, 1, 0, 1);
      // T4: no strobes for 50 clocks mid-window.
      for (int i = 0; i < 5; i++) drive(1, 1, 1, 1);
      for (int i = 0; i < 50; i++) drive(1, 1, 0, $urandom_range(0, 1) == 1);
      // T5: async reset in COUNT, then recovery.
      run_until(2, 200, "reach_count");
      drive(0, 1, 1, 1);
      drive(0, 1, 0, 1);
      for (int i = 0; i < 6; i++) drive(1, 1, i[0], 1);
`ifdef BER_AUTO_RESYNC_EN
      // T6: 7 bad strobes then a good one keeps COUNT; 8 bad strobes resync.
      run_until(2, 200, "reach_count_los");
      for (int i = 0; i < 7; i++) begin drive(1, 1, 1, 0); drive(1, 1, 0, 0); end
      drive(1, 1, 1, 1);
      for (int i = 0; i < 8; i++) begin drive(1, 1, 1, 0); drive(1, 1, 0, 1); end
      for (int i = 0; i < 4; i++) drive(1, 1, 0, 1);
`endif
      // Randomized traffic.
      for (int i = 0; i < 3000; i++)
         drive($urandom_range(0, 599) != 0, $urandom_range(0, 59) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 3);
      k = 0;
      while (exp_q.size() > 0 && k < 10) begin @(posedge clk); #2; k++; end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
